exec_stage_ctrl: RTL and testbench
==================================

EXEC_STAGE_CTRL -- requirements
Module: exec_stage_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- D_SIZE, 32, data/operand width.
- A_SIZE, 10, memory and program address width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- r1_opcode  in  7  opcode from the read/execute pipeline register.
- r1_destination  in  3  destination register index.
- r1_operand_a  in  D_SIZE  operand A.
- r1_operand_b  in  D_SIZE  operand B.
- r2_pc_halt  out  1  freezes the fetch stage and the pipeline register.
- r2_pc_flush  out  1  turns the pipeline register into a NOP on the next edge.
- pc_load  out  1  combinational; loads the PC with pc_target.
- pc_target  out  A_SIZE  combinational; the jump address.
- mem_rd_req  out  1  data-memory read request.
- mem_rd_addr  out  A_SIZE  read address.
- mem_rd_ack  in  1  read data valid.
- mem_rd_data  in  D_SIZE  read data.
- mem_wr_en  out  1  registered one-cycle write strobe.
- mem_wr_addr  out  A_SIZE  write address.
- mem_wr_data  out  D_SIZE  write data.
- wb_en  out  1  registered one-cycle register-file write strobe.
- wb_dest  out  3  write-back register index.
- wb_data  out  D_SIZE  write-back data.

Function
REQ-003 Opcodes SHALL be decoded as follows:
- NOP = 0000000, ADD = 0000001, SUB = 0000010, AND = 0000011, OR = 0000100, XOR = 0000101.
- LOAD = 0001000, STORE = 0001001, JMP = 0010000, JMPZ = 0010001, HALT = 1111111.
- Any other value SHALL be executed as NOP.
REQ-004 The FSM SHALL have exactly three states: EXEC, LOAD_WAIT and HALTED.
REQ-005 In EXEC, an ALU opcode SHALL produce, on the next edge: wb_en = 1, wb_dest = r1_destination, wb_data = (A op B) mod 2^D_SIZE. SUB is A-B. Latency is 1 cycle.
REQ-006 In EXEC, STORE SHALL produce, on the next edge: mem_wr_en = 1, mem_wr_addr = operand_a[A_SIZE-1:0], mem_wr_data = operand_b.
REQ-007 In EXEC, JMP SHALL drive pc_load = 1, r2_pc_flush = 1 and pc_target = operand_a[A_SIZE-1:0] in the same cycle (combinational).
REQ-008 In EXEC, JMPZ SHALL behave as JMP only when operand_b == 0; otherwise it is a NOP.
REQ-009 In EXEC, LOAD SHALL:
- drive r2_pc_halt = 1 combinationally;
- latch mem_rd_addr = operand_a[A_SIZE-1:0] and the destination index;
- move the FSM to LOAD_WAIT.
REQ-010 In LOAD_WAIT:
- mem_rd_req SHALL be 1 and mem_rd_addr SHALL be held stable.
- r2_pc_halt SHALL equal !mem_rd_ack.
- r1 contents SHALL be ignored.
REQ-011 A LOAD_WAIT cycle with mem_rd_ack = 1 SHALL, on the next edge:
- set wb_en = 1, wb_data = mem_rd_data, wb_dest = latched index;
- drop mem_rd_req;
- return the FSM to EXEC.
A wait of zero extra cycles is legal (ack in the first LOAD_WAIT cycle).
REQ-012 HALT in EXEC SHALL move the FSM to HALTED. In HALTED, r2_pc_halt SHALL be held at 1 and no other strobe asserted until reset.
REQ-013 r2_pc_flush and pc_load SHALL never be asserted in LOAD_WAIT or HALTED.
REQ-014 wb_en and mem_wr_en SHALL be high for exactly one cycle per instruction.

Reset
REQ-015 While rst = 1 (asynchronous), the FSM SHALL be in EXEC and all registered outputs SHALL be 0, including mem_rd_req, mem_rd_addr, wb_* and mem_wr_*.
REQ-016 Reset asserted during LOAD_WAIT or HALTED SHALL abort immediately: mem_rd_req falls without waiting for clk, and a late mem_rd_ack is ignored.

Configuration
REQ-017 With macro EXEC_STALL_CNT_EN defined:
- output stall_cnt [15:0] SHALL exist;
- stall_cnt increments once per cycle in which r2_pc_halt = 1 and the FSM is not HALTED;
- stall_cnt saturates at 16'hFFFF and resets to 0.
Without the macro, the port and counter SHALL be absent.

Verification
REQ-018 The bench SHALL cover these scenarios:
- ADD with A = 32'hFFFF_FFFF, B = 2, dest = 5 -> one cycle later wb_en = 1, wb_dest = 5, wb_data = 1.
- LOAD with A = 10'h3A5, ack after 3 cycles, data = 32'hCAFE -> r2_pc_halt high 4 cycles; mem_rd_req high 3 cycles then ack cycle; wb_data = 32'hCAFE one cycle after ack.
- JMPZ with A = 10'h040, B = 0 -> pc_load = 1, pc_target = 10'h040, r2_pc_flush = 1 in the same cycle. The same with B = 1 -> all three stay 0.
- STORE with A = 10'h011, B = 32'h55 -> next cycle mem_wr_en = 1 for 1 cycle, addr = 10'h011, data = 32'h55.
- HALT, then 10 cycles of ADD on the inputs -> r2_pc_halt = 1 throughout, no wb_en. Then rst pulse -> EXEC, outputs 0.
- rst asserted in the 2nd LOAD_WAIT cycle -> mem_rd_req = 0 before the next clk edge, no wb_en after ack. With EXEC_STALL_CNT_EN, stall_cnt = 0.

Source files
------------

// File: rtl/exec_stage_ctrl.sv
// Execute-stage controller: ALU write-back, store strobe, jumps, multi-cycle loads and halt.
// Optional stall counter output enabled by defining EXEC_STALL_CNT_EN.
module exec_stage_ctrl #(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        r1_opcode,
    input  logic [2:0]        r1_destination,
    input  logic [D_SIZE-1:0] r1_operand_a,
    input  logic [D_SIZE-1:0] r1_operand_b,
    output logic              r2_pc_halt,
    output logic              r2_pc_flush,
    output logic              pc_load,
    output logic [A_SIZE-1:0] pc_target,
    output logic              mem_rd_req,
    output logic [A_SIZE-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [D_SIZE-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [A_SIZE-1:0] mem_wr_addr,
    output logic [D_SIZE-1:0] mem_wr_data,
    output logic              wb_en,
    output logic [2:0]        wb_dest,
    output logic [D_SIZE-1:0] wb_data
`ifdef EXEC_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [6:0] OP_ADD   = 7'b0000001;
    localparam logic [6:0] OP_SUB   = 7'b0000010;
    localparam logic [6:0] OP_AND   = 7'b0000011;
    localparam logic [6:0] OP_OR    = 7'b0000100;
    localparam logic [6:0] OP_XOR   = 7'b0000101;
    localparam logic [6:0] OP_LOAD  = 7'b0001000;
    localparam logic [6:0] OP_STORE = 7'b0001001;
    localparam logic [6:0] OP_JMP   = 7'b0010000;
    localparam logic [6:0] OP_JMPZ  = 7'b0010001;
    localparam logic [6:0] OP_HALT  = 7'b1111111;

    typedef enum logic [1:0] {EXEC, LOAD_WAIT, HALTED} state_t;

    // Two's-complement wraparound gives the required mod 2^D_SIZE result.
    function automatic logic signed [D_SIZE-1:0] alu_result(
        input logic [6:0]               op,
        input logic signed [D_SIZE-1:0] a,
        input logic signed [D_SIZE-1:0] b
    );
        case (op)
            OP_ADD:  alu_result = a + b;
            OP_SUB:  alu_result = a - b;
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_XOR:  alu_result = a ^ b;
            default: alu_result = '0;
        endcase
    endfunction

    state_t state, state_nxt;

    logic signed [D_SIZE-1:0] opa_s, opb_s;

    logic              wb_en_p1,    wb_en_nxt;
    logic [2:0]        wb_dest_p1,  wb_dest_nxt;
    logic [D_SIZE-1:0] wb_data_p1,  wb_data_nxt;
    logic              wr_en_p1,    wr_en_nxt;
    logic [A_SIZE-1:0] wr_addr_p1,  wr_addr_nxt;
    logic [D_SIZE-1:0] wr_data_p1,  wr_data_nxt;
    logic              rd_req_p1;
    logic [A_SIZE-1:0] rd_addr_p1,  rd_addr_nxt;
    logic [2:0]        rd_dest_p1,  rd_dest_nxt;

    assign opa_s = $signed(r1_operand_a);
    assign opb_s = $signed(r1_operand_b);

    // p0: decode of the r1 register and FSM next state
    always_comb begin
        state_nxt   = state;
        r2_pc_halt  = 1'b0;
        r2_pc_flush = 1'b0;
        pc_load     = 1'b0;
        pc_target   = '0;
        wb_en_nxt   = 1'b0;
        wb_dest_nxt = wb_dest_p1;
        wb_data_nxt = wb_data_p1;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_p1;
        wr_data_nxt = wr_data_p1;
        rd_addr_nxt = rd_addr_p1;
        rd_dest_nxt = rd_dest_p1;
        case (state)
            EXEC: begin
                case (r1_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        wb_en_nxt   = 1'b1;
                        wb_dest_nxt = r1_destination;
                        wb_data_nxt = alu_result(r1_opcode, opa_s, opb_s);
                    end
                    OP_STORE: begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = r1_operand_a[A_SIZE-1:0];
                        wr_data_nxt = r1_operand_b;
                    end
                    OP_JMP: begin
                        pc_load     = 1'b1;
                        r2_pc_flush = 1'b1;
                        pc_target   = r1_operand_a[A_SIZE-1:0];
                    end
                    OP_JMPZ: begin
                        if (r1_operand_b == '0) begin
                            pc_load     = 1'b1;
                            r2_pc_flush = 1'b1;
                            pc_target   = r1_operand_a[A_SIZE-1:0];
                        end
                    end
                    OP_LOAD: begin
                        r2_pc_halt  = 1'b1;
                        rd_addr_nxt = r1_operand_a[A_SIZE-1:0];
                        rd_dest_nxt = r1_destination;
                        state_nxt   = LOAD_WAIT;
                    end
                    OP_HALT: state_nxt = HALTED;
                    default: ;
                endcase
            end
            LOAD_WAIT: begin
                r2_pc_halt = !mem_rd_ack;
                if (mem_rd_ack) begin
                    wb_en_nxt   = 1'b1;
                    wb_dest_nxt = rd_dest_p1;
                    wb_data_nxt = mem_rd_data;
                    state_nxt   = EXEC;
                end
            end
            HALTED:  r2_pc_halt = 1'b1;
            default: state_nxt = EXEC;
        endcase
    end

    // p1: registered strobes, addresses and data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EXEC;
            wb_en_p1   <= 1'b0;
            wb_dest_p1 <= '0;
            wb_data_p1 <= '0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            rd_req_p1  <= 1'b0;
            rd_addr_p1 <= '0;
            rd_dest_p1 <= '0;
        end else begin
            state      <= state_nxt;
            wb_en_p1   <= wb_en_nxt;
            wb_dest_p1 <= wb_dest_nxt;
            wb_data_p1 <= wb_data_nxt;
            wr_en_p1   <= wr_en_nxt;
            wr_addr_p1 <= wr_addr_nxt;
            wr_data_p1 <= wr_data_nxt;
            rd_req_p1  <= (state_nxt == LOAD_WAIT);
            rd_addr_p1 <= rd_addr_nxt;
            rd_dest_p1 <= rd_dest_nxt;
        end
    end

    assign wb_en       = wb_en_p1;
    assign wb_dest     = wb_dest_p1;
    assign wb_data     = wb_data_p1;
    assign mem_wr_en   = wr_en_p1;
    assign mem_wr_addr = wr_addr_p1;
    assign mem_wr_data = wr_data_p1;
    assign mem_rd_req  = rd_req_p1;
    assign mem_rd_addr = rd_addr_p1;

`ifdef EXEC_STALL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_p1;

    // Halted cycles are not stalls; only load waits count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_p1 <= '0;
        else if (r2_pc_halt && state != HALTED)
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end

    assign stall_cnt = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_exec_stage_ctrl.sv
// Randomized self-checking bench for exec_stage_ctrl against a behavioural instruction model.
module tb_exec_stage_ctrl;
    localparam logic [6:0] NOP = 7'd0, ADD = 7'd1, SUB = 7'd2, ANDO = 7'd3, ORO = 7'd4, XORO = 7'd5;
    localparam logic [6:0] LOAD = 7'd8, STORE = 7'd9, JMP = 7'd16, JMPZ = 7'd17, HALT = 7'd127;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  r1_opcode = '0;
    logic [2:0]  r1_destination = '0;
    logic [31:0] r1_operand_a = '0, r1_operand_b = '0;
    logic        r2_pc_halt, r2_pc_flush, pc_load, mem_rd_req, mem_wr_en, wb_en;
    logic [9:0]  pc_target, mem_rd_addr, mem_wr_addr;
    logic        mem_rd_ack = 1'b0;
    logic [31:0] mem_rd_data = '0, mem_wr_data, wb_data;
    logic [2:0]  wb_dest;
`ifdef EXEC_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int total = 0;
    int bad = 0;

    exec_stage_ctrl #(.D_SIZE(32), .A_SIZE(10)) dut (
        .clk(clk), .rst(rst),
        .r1_opcode(r1_opcode), .r1_destination(r1_destination),
        .r1_operand_a(r1_operand_a), .r1_operand_b(r1_operand_b),
        .r2_pc_halt(r2_pc_halt), .r2_pc_flush(r2_pc_flush),
        .pc_load(pc_load), .pc_target(pc_target),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
`ifdef EXEC_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] op, input logic [2:0] d, input logic [31:0] a, input logic [31:0] b);
        r1_opcode = op; r1_destination = d; r1_operand_a = a; r1_operand_b = b;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Architectural result of one instruction executed in the normal state.
    function automatic void model_alu(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic en, output logic [31:0] r);
        en = 1'b1;
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            ANDO: r = a & b;
            ORO:  r = a | b;
            XORO: r = a ^ b;
            default: begin en = 1'b0; r = '0; end
        endcase
    endfunction

    task automatic test_reset();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        repeat (2) step();
        total++;
        if ({r2_pc_halt, r2_pc_flush, pc_load, pc_target, mem_rd_req, mem_rd_addr} !== 24'd0) begin
            bad++; $display("FAIL reset_ctrl got=%h exp=0", {r2_pc_halt, r2_pc_flush, pc_load, pc_target, mem_rd_req, mem_rd_addr});
        end
        total++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, wb_en, wb_dest, wb_data} !== 79'd0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {mem_wr_en, mem_wr_addr, mem_wr_data, wb_en, wb_dest, wb_data});
        end
        rst = 1'b0;
        step();
        total++;
        if ({wb_en, mem_wr_en, mem_rd_req} !== 3'b000) begin
            bad++; $display("FAIL post_reset_nop got=%b exp=000", {wb_en, mem_wr_en, mem_rd_req});
        end
    endtask

    task automatic test_add_wrap();
        drive(ADD, 3'd5, 32'hFFFF_FFFF, 32'd2);
        step();
        total++;
        if ({wb_en, wb_dest, wb_data} !== {1'b1, 3'd5, 32'd1}) begin
            bad++; $display("FAIL add_wrap got en=%b dest=%0d data=%h exp en=1 dest=5 data=1", wb_en, wb_dest, wb_data);
        end
        drive(NOP, 3'd0, 32'd0, 32'd0);
        step();
        total++;
        if (wb_en !== 1'b0) begin bad++; $display("FAIL add_one_cycle got wb_en=%b exp=0", wb_en); end
    endtask

    task automatic test_alu_random();
        logic [6:0] op;
        logic [31:0] a, b, r;
        logic [2:0] d;
        logic en;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) < 6) op = 7'($urandom_range(0, 5));
            else begin
                op = 7'($urandom_range(0, 127));
                if (op == LOAD || op == STORE || op == JMP || op == JMPZ || op == HALT) op = NOP;
            end
            a = $urandom; b = $urandom; d = 3'($urandom);
            drive(op, d, a, b);
            model_alu(op, a, b, en, r);
            #1;
            total++;
            if ({r2_pc_halt, pc_load, r2_pc_flush} !== 3'b000) begin
                bad++; $display("FAIL alu_comb op=%0d got=%b exp=000", op, {r2_pc_halt, pc_load, r2_pc_flush});
            end
            step();
            total++;
            if (wb_en !== en || mem_wr_en !== 1'b0 || (en && (wb_dest !== d || wb_data !== r))) begin
                bad++; $display("FAIL alu_rand op=%0d got en=%b dest=%0d data=%h exp en=%b dest=%0d data=%h",
                                op, wb_en, wb_dest, wb_data, en, d, r);
            end
        end
        drive(NOP, 3'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_store();
        drive(STORE, 3'd7, 32'hABCD_0011, 32'h55);
        step();
        total++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, wb_en} !== {1'b1, 10'h011, 32'h55, 1'b0}) begin
            bad++; $display("FAIL store got en=%b addr=%h data=%h wb=%b exp en=1 addr=011 data=55 wb=0",
                            mem_wr_en, mem_wr_addr, mem_wr_data, wb_en);
        end
        drive(NOP, 3'd0, 32'd0, 32'd0);
        step();
        total++;
        if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL store_one_cycle got=%b exp=0", mem_wr_en); end
    endtask

    task automatic test_jump();
        logic [31:0] a;
        drive(JMPZ, 3'd0, 32'h040, 32'd0);
        #1;
        total++;
        if ({pc_load, pc_target, r2_pc_flush} !== {1'b1, 10'h040, 1'b1}) begin
            bad++; $display("FAIL jmpz_taken got=%h exp=%h", {pc_load, pc_target, r2_pc_flush}, {1'b1, 10'h040, 1'b1});
        end
        drive(JMPZ, 3'd0, 32'h040, 32'd1);
        #1;
        total++;
        if ({pc_load, pc_target, r2_pc_flush} !== 12'd0) begin
            bad++; $display("FAIL jmpz_not_taken got=%h exp=0", {pc_load, pc_target, r2_pc_flush});
        end
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            drive(JMP, 3'd0, a, $urandom);
            #1;
            total++;
            if ({pc_load, pc_target, r2_pc_flush, r2_pc_halt} !== {1'b1, a[9:0], 1'b1, 1'b0}) begin
                bad++; $display("FAIL jmp got=%h exp=%h", {pc_load, pc_target, r2_pc_flush, r2_pc_halt}, {1'b1, a[9:0], 1'b1, 1'b0});
            end
        end
        step();
        total++;
        if ({wb_en, mem_wr_en, mem_rd_req} !== 3'b000) begin
            bad++; $display("FAIL jmp_no_strobe got=%b exp=000", {wb_en, mem_wr_en, mem_rd_req});
        end
        drive(NOP, 3'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_load(input int n, input logic [31:0] a, input logic [31:0] data, input logic [2:0] d);
        int halt_cycles = 0;
`ifdef EXEC_STALL_CNT_EN
        logic [15:0] stall0 = stall_cnt;
`endif
        drive(LOAD, d, a, $urandom);
        #1;
        if (r2_pc_halt) halt_cycles++;
        total++;
        if ({r2_pc_halt, mem_rd_req} !== 2'b10) begin
            bad++; $display("FAIL load_issue got halt,req=%b exp=10", {r2_pc_halt, mem_rd_req});
        end
        step();
        for (int i = 0; i < n; i++) begin
            drive(ADD, 3'($urandom), $urandom, $urandom);
            mem_rd_ack = 1'b0;
            #1;
            if (r2_pc_halt) halt_cycles++;
            total++;
            if ({mem_rd_req, mem_rd_addr, r2_pc_halt, pc_load, r2_pc_flush} !== {1'b1, a[9:0], 3'b100}) begin
                bad++; $display("FAIL load_wait got=%h exp=%h", {mem_rd_req, mem_rd_addr, r2_pc_halt, pc_load, r2_pc_flush},
                                {1'b1, a[9:0], 3'b100});
            end
            step();
            total++;
            if (wb_en !== 1'b0) begin bad++; $display("FAIL load_wait_wb got=%b exp=0", wb_en); end
        end
        mem_rd_ack = 1'b1; mem_rd_data = data;
        #1;
        total++;
        if ({mem_rd_req, mem_rd_addr, r2_pc_halt} !== {1'b1, a[9:0], 1'b0}) begin
            bad++; $display("FAIL load_ack_cycle got=%h exp=%h", {mem_rd_req, mem_rd_addr, r2_pc_halt}, {1'b1, a[9:0], 1'b0});
        end
        step();
        mem_rd_ack = 1'b0; mem_rd_data = $urandom;
        total++;
        if ({wb_en, wb_dest, wb_data, mem_rd_req} !== {1'b1, d, data, 1'b0}) begin
            bad++; $display("FAIL load_wb got en=%b dest=%0d data=%h req=%b exp en=1 dest=%0d data=%h req=0",
                            wb_en, wb_dest, wb_data, mem_rd_req, d, data);
        end
        total++;
        if (halt_cycles != n + 1) begin bad++; $display("FAIL load_halt_cycles got=%0d exp=%0d", halt_cycles, n + 1); end
`ifdef EXEC_STALL_CNT_EN
        total++;
        if (stall_cnt !== stall0 + 16'(n + 1)) begin
            bad++; $display("FAIL load_stall_cnt got=%0d exp=%0d", stall_cnt, stall0 + 16'(n + 1));
        end
`endif
        drive(NOP, 3'd0, 32'd0, 32'd0);
        step();
        total++;
        if (wb_en !== 1'b0) begin bad++; $display("FAIL load_wb_one_cycle got=%b exp=0", wb_en); end
    endtask

    task automatic test_halt();
        logic [6:0] op;
        drive(HALT, 3'd0, 32'd0, 32'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: op = JMP;
                1: op = STORE;
                2: op = LOAD;
                default: op = ADD;
            endcase
            drive(op, 3'($urandom), $urandom, 32'd0);
            #1;
            total++;
            if ({r2_pc_halt, pc_load, r2_pc_flush, mem_rd_req} !== 4'b1000) begin
                bad++; $display("FAIL halted_comb op=%0d got=%b exp=1000", op, {r2_pc_halt, pc_load, r2_pc_flush, mem_rd_req});
            end
            step();
            total++;
            if ({wb_en, mem_wr_en} !== 2'b00) begin
                bad++; $display("FAIL halted_strobe got=%b exp=00", {wb_en, mem_wr_en});
            end
        end
        drive(NOP, 3'd0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        total++;
        if ({r2_pc_halt, wb_en, mem_wr_en, mem_rd_req, wb_data} !== 36'd0) begin
            bad++; $display("FAIL halt_reset got=%h exp=0", {r2_pc_halt, wb_en, mem_wr_en, mem_rd_req, wb_data});
        end
        step();
        rst = 1'b0;
        drive(ADD, 3'd2, 32'd3, 32'd4);
        step();
        total++;
        if ({wb_en, wb_dest, wb_data} !== {1'b1, 3'd2, 32'd7}) begin
            bad++; $display("FAIL halt_resume got en=%b dest=%0d data=%h exp en=1 dest=2 data=7", wb_en, wb_dest, wb_data);
        end
        drive(NOP, 3'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_reset_in_load();
        drive(LOAD, 3'd6, 32'h155, 32'd0);
        step();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        mem_rd_ack = 1'b0;
        step();
        total++;
        if (mem_rd_req !== 1'b1) begin bad++; $display("FAIL rst_load_pre got req=%b exp=1", mem_rd_req); end
        rst = 1'b1;
        #1;
        total++;
        if ({mem_rd_req, mem_rd_addr, wb_en, r2_pc_halt} !== 13'd0) begin
            bad++; $display("FAIL rst_load_async got=%h exp=0", {mem_rd_req, mem_rd_addr, wb_en, r2_pc_halt});
        end
        mem_rd_ack = 1'b1; mem_rd_data = 32'h1234_5678;
        step();
        rst = 1'b0;
        step();
        total++;
        if ({wb_en, mem_rd_req, r2_pc_halt} !== 3'b000) begin
            bad++; $display("FAIL rst_load_late_ack got=%b exp=000", {wb_en, mem_rd_req, r2_pc_halt});
        end
`ifdef EXEC_STALL_CNT_EN
        total++;
        if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_load_stall got=%0d exp=0", stall_cnt); end
`endif
        mem_rd_ack = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_alu_random();
        test_store();
        test_jump();
        test_load(3, 32'h0000_03A5, 32'h0000_CAFE, 3'd4);
        test_load(0, 32'hFFFF_F123, 32'hDEAD_BEEF, 3'd1);
        test_load(int'($urandom_range(1, 6)), $urandom, $urandom, 3'($urandom));
        test_halt();
        test_reset_in_load();
        test_load(2, 32'h0000_0200, 32'h0BAD_F00D, 3'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
